// File: rtl/fpu_seq_pkg.sv
// Shared types and constants for the FP adder op sequencer.
//   fpu_mode_e   : caller operation codes (ADD, SUB); other codes are illegal
//   EXC_*        : exception codes returned on Res_exc
//   seq_state_e  : sequencer FSM states
package fpu_seq_pkg;

  typedef enum logic [2:0] {
    FPU_ADD = 3'b000,
    FPU_SUB = 3'b001
  } fpu_mode_e;

  localparam logic [2:0] EXC_NONE      = 3'b000;
  localparam logic [2:0] EXC_UNDERFLOW = 3'b001;
  localparam logic [2:0] EXC_OVERFLOW  = 3'b010;
  localparam logic [2:0] EXC_ILLEGAL   = 3'b100;
  localparam logic [2:0] EXC_TIMEOUT   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } seq_state_e;

endpackage

// File: rtl/fpu_seq_fifo.sv
// Synchronous request FIFO for the op sequencer.
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_push, i_wdata: write one entry (caller guarantees not full unless popping)
//   i_pop, o_rdata : o_rdata is the current head; i_pop retires it
//   o_full, o_empty: occupancy flags derived from a separate count
module fpu_seq_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_full,
  output logic              o_empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (i_push && !i_pop)      r_count <= r_count + 1'b1;
      else if (!i_push && i_pop) r_count <= r_count - 1'b1;
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/fpu_add_op_sequencer.sv
// Front end of the FP adder controller: buffers add/sub requests, issues them one
// at a time on the controller's Datain/Data_valid interface, and returns the
// result, exception code and tag on a valid/ready port. SUB is sent as ADD with
// operand B's sign inverted; illegal modes are answered locally with EXC_ILLEGAL.
// Ports:
//   CLK, RSTn                     : clock, synchronous active-low reset
//   Op_valid/Op_ready/Op_a/Op_b/Op_mode/Op_tag : request port
//   Res_valid/Res_ready/Res_data/Res_exc/Res_tag : result port
//   Add_Datain1/2, Add_Data_valid, Add_Mode      : to adder controller
//   Add_Dataout, Add_Dataout_valid, Add_Exc      : from adder controller
// Optional feature: define FPU_SEQ_TIMEOUT_EN to enable a TIMEOUT-cycle watchdog
// in S_WAIT that answers with EXC_TIMEOUT.
module fpu_add_op_sequencer
  import fpu_seq_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TAG_W      = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             Op_valid,
  output logic             Op_ready,
  input  logic [31:0]      Op_a,
  input  logic [31:0]      Op_b,
  input  logic [2:0]       Op_mode,
  input  logic [TAG_W-1:0] Op_tag,
  output logic             Res_valid,
  input  logic             Res_ready,
  output logic [31:0]      Res_data,
  output logic [2:0]       Res_exc,
  output logic [TAG_W-1:0] Res_tag,
  output logic [31:0]      Add_Datain1,
  output logic [31:0]      Add_Datain2,
  output logic             Add_Data_valid,
  output logic [2:0]       Add_Mode,
  input  logic [31:0]      Add_Dataout,
  input  logic             Add_Dataout_valid,
  input  logic [2:0]       Add_Exc
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_cfg
    $error("fpu_add_op_sequencer: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
  end

  localparam int unsigned ENTRY_W = 3 + TAG_W + 64;

  seq_state_e r_state, w_state_nxt;

  logic               w_push, w_pop, w_full, w_empty;
  logic [ENTRY_W-1:0] w_head;
  logic [2:0]         w_h_mode;
  logic [TAG_W-1:0]   w_h_tag;
  logic [31:0]        w_h_a, w_h_b;
  logic               w_legal;
  logic               w_issue, w_capture, w_timeout, w_res_valid;

  logic [31:0]        r_din1, r_din2, r_res_data;
  logic [2:0]         r_res_exc;
  logic [TAG_W-1:0]   r_res_tag;

  fpu_seq_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst_n (RSTn),
    .i_push  (w_push),
    .i_wdata ({Op_mode, Op_tag, Op_a, Op_b}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign {w_h_mode, w_h_tag, w_h_a, w_h_b} = w_head;
  assign w_legal = (w_h_mode == FPU_ADD) || (w_h_mode == FPU_SUB);

  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign Op_ready = !w_full || w_pop;
  assign w_push   = Op_valid && Op_ready;

`ifdef FPU_SEQ_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] r_wait_cnt;

  always_ff @(posedge CLK) begin
    if (!RSTn)                  r_wait_cnt <= '0;
    else if (w_issue)           r_wait_cnt <= '0;
    else if (r_state == S_WAIT) r_wait_cnt <= r_wait_cnt + 1'b1;
  end
`endif

  always_ff @(posedge CLK) begin
    if (!RSTn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_issue     = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    w_res_valid = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = w_legal ? S_ISSUE : S_RESP;
        end
      end
      S_ISSUE: begin
        w_issue     = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (Add_Dataout_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RESP;
        end
`ifdef FPU_SEQ_TIMEOUT_EN
        else if (r_wait_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_RESP;
        end
`endif
      end
      S_RESP: begin
        w_res_valid = 1'b1;
        if (Res_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operands are loaded at pop and simply held until the next pop, which keeps
  // them stable across S_ISSUE and S_WAIT. The tag is also latched at pop.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_din1     <= '0;
      r_din2     <= '0;
      r_res_data <= '0;
      r_res_exc  <= '0;
      r_res_tag  <= '0;
    end else begin
      if (w_pop) begin
        r_res_tag <= w_h_tag;
        if (w_legal) begin
          r_din1 <= w_h_a;
          r_din2 <= {w_h_b[31] ^ (w_h_mode == FPU_SUB), w_h_b[30:0]};
        end else begin
          r_res_data <= '0;
          r_res_exc  <= EXC_ILLEGAL;
        end
      end
      if (w_capture) begin
        r_res_data <= Add_Dataout;
        r_res_exc  <= Add_Exc;
      end
      if (w_timeout) begin
        r_res_data <= '0;
        r_res_exc  <= EXC_TIMEOUT;
      end
    end
  end

  assign Add_Datain1    = r_din1;
  assign Add_Datain2    = r_din2;
  assign Add_Data_valid = w_issue;
  assign Add_Mode       = FPU_ADD;
  assign Res_valid      = w_res_valid;
  assign Res_data       = r_res_data;
  assign Res_exc        = r_res_exc;
  assign Res_tag        = r_res_tag;

endmodule

// File: tb/tb_fpu_add_op_sequencer.sv
// Self-checking bench for fpu_add_op_sequencer. A queue of accepted ops is the
// reference: the head is the op in service; results must match the head, legal
// heads must be issued exactly once with the right operands, and the bench's
// controller stand-in supplies the reply that the result must carry.
module tb_fpu_add_op_sequencer;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned TAG_W  = 4;
  localparam int unsigned TO_LIM = 64;

  logic             CLK = 1'b0;
  logic             RSTn = 1'b0;
  logic             Op_valid = 1'b0;
  logic             Op_ready;
  logic [31:0]      Op_a = '0;
  logic [31:0]      Op_b = '0;
  logic [2:0]       Op_mode = '0;
  logic [TAG_W-1:0] Op_tag = '0;
  logic             Res_valid;
  logic             Res_ready = 1'b0;
  logic [31:0]      Res_data;
  logic [2:0]       Res_exc;
  logic [TAG_W-1:0] Res_tag;
  logic [31:0]      Add_Datain1, Add_Datain2;
  logic             Add_Data_valid;
  logic [2:0]       Add_Mode;
  logic [31:0]      Add_Dataout = '0;
  logic             Add_Dataout_valid = 1'b0;
  logic [2:0]       Add_Exc = '0;

  fpu_add_op_sequencer #(
    .FIFO_DEPTH (DEPTH),
    .TAG_W      (TAG_W),
    .TIMEOUT    (TO_LIM)
  ) dut (
    .CLK               (CLK),
    .RSTn              (RSTn),
    .Op_valid          (Op_valid),
    .Op_ready          (Op_ready),
    .Op_a              (Op_a),
    .Op_b              (Op_b),
    .Op_mode           (Op_mode),
    .Op_tag            (Op_tag),
    .Res_valid         (Res_valid),
    .Res_ready         (Res_ready),
    .Res_data          (Res_data),
    .Res_exc           (Res_exc),
    .Res_tag           (Res_tag),
    .Add_Datain1       (Add_Datain1),
    .Add_Datain2       (Add_Datain2),
    .Add_Data_valid    (Add_Data_valid),
    .Add_Mode          (Add_Mode),
    .Add_Dataout       (Add_Dataout),
    .Add_Dataout_valid (Add_Dataout_valid),
    .Add_Exc           (Add_Exc)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0]      a;
    logic [31:0]      b;
    logic [2:0]       mode;
    logic [TAG_W-1:0] tag;
  } op_t;

  op_t q[$];
  logic [TAG_W-1:0] res_tags[$];
  int total = 0, bad = 0, cyc = 0;
  bit cur_issued = 0, cur_replied = 0, outstanding = 0, exp_res_next = 0;
  bit prev_dv = 0, prev_hold = 0, pushed_now = 0;
  logic [31:0] cur_rep_data, exp_d1, exp_d2, ctl_data;
  logic [2:0]  cur_rep_exc, ctl_exc;
  int ctl_wait = 0;
  bit ctl_mute = 0, stray_en = 0, ovr_en = 0;
  logic [31:0] ovr_data = '0;
  logic [2:0]  ovr_exc = '0;
  int ovr_delay = 1;
  int issue_cnt = 0, res_cnt = 0, stray_cnt = 0;
  int last_push_cyc = 0, last_issue_cyc = 0, last_res_cyc = 0;
  logic [31:0] last_issue_d2, last_res_data;
  logic [2:0]  last_res_exc;
  logic [TAG_W-1:0] last_res_tag;

  function automatic bit legal(input logic [2:0] m);
    return (m == 3'b000) || (m == 3'b001);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_true(input string name, input bit c);
    total++;
    if (!c) begin
      bad++;
      $display("FAIL %s: condition false, want true (cycle %0d)", name, cyc);
    end
  endtask

  // Runs at the falling edge: checks outputs against the model, then drives the
  // controller stand-in for the next rising edge.
  task automatic check_cycle();
    op_t h;
    logic [31:0] eb, ed;
    logic [2:0]  ee;
    cyc++;
    pushed_now = 0;
    if (!RSTn) begin
      q.delete();
      cur_issued = 0; cur_replied = 0; outstanding = 0;
      exp_res_next = 0; prev_dv = 0; prev_hold = 0;
    end else begin
      chk("add_mode", 32'(Add_Mode), 32'd0);
      if (q.size() < DEPTH)      chk_true("op_ready_free", Op_ready === 1'b1);
      else if (q.size() > DEPTH) chk_true("op_ready_full", Op_ready === 1'b0);
      if (exp_res_next) chk_true("res_latency", Res_valid === 1'b1);
      exp_res_next = 0;
      if (prev_hold) chk_true("res_hold", Res_valid === 1'b1);
      if (Res_valid === 1'b1) begin
        if (q.size() == 0) begin
          chk("res_spurious", 32'(Res_valid), 32'd0);
        end else begin
          h = q[0];
          if (!legal(h.mode)) begin
            ed = '0; ee = 3'b100;
          end else if (cur_replied) begin
            ed = cur_rep_data; ee = cur_rep_exc;
          end else begin
`ifdef FPU_SEQ_TIMEOUT_EN
            ed = '0; ee = 3'b111;
`else
            ed = 32'hxxxx_xxxx; ee = 3'bxxx;
            chk_true("res_before_reply", 1'b0);
`endif
          end
          chk("res_data", Res_data, ed);
          chk("res_exc", 32'(Res_exc), 32'(ee));
          chk("res_tag", 32'(Res_tag), 32'(h.tag));
          if (Res_ready) begin
            last_res_data = Res_data; last_res_exc = Res_exc; last_res_tag = Res_tag;
            last_res_cyc = cyc;
            res_tags.push_back(Res_tag);
            res_cnt++;
            void'(q.pop_front());
            cur_issued = 0; cur_replied = 0; outstanding = 0;
          end
        end
      end
      prev_hold = (Res_valid === 1'b1) && !Res_ready;
    end

    Add_Dataout_valid = 1'b0;
    if (ctl_wait > 0) begin
      ctl_wait--;
      if (ctl_wait == 0 && !ctl_mute) begin
        Add_Dataout_valid = 1'b1; Add_Dataout = ctl_data; Add_Exc = ctl_exc;
        if (outstanding && RSTn) begin
          cur_replied = 1; cur_rep_data = ctl_data; cur_rep_exc = ctl_exc;
          outstanding = 0; exp_res_next = 1;
        end else begin
          stray_cnt++;
        end
      end
    end else if (stray_en && !outstanding && $urandom_range(0, 7) == 0) begin
      Add_Dataout_valid = 1'b1; Add_Dataout = $urandom; Add_Exc = 3'($urandom_range(0, 7));
      stray_cnt++;
    end

    if (RSTn) begin
      if (Add_Data_valid === 1'b1) begin
        issue_cnt++;
        last_issue_cyc = cyc;
        last_issue_d2  = Add_Datain2;
        chk_true("issue_single_pulse", !prev_dv);
        if (q.size() == 0 || cur_issued || !legal(q[0].mode)) begin
          chk_true("issue_expected", 1'b0);
        end else begin
          h  = q[0];
          eb = h.b;
          if (h.mode == 3'b001) eb[31] = ~eb[31];
          chk("datain1", Add_Datain1, h.a);
          chk("datain2", Add_Datain2, eb);
          exp_d1 = h.a; exp_d2 = eb;
          cur_issued = 1; outstanding = 1;
          ctl_wait = ovr_en ? ovr_delay : int'($urandom_range(1, 8));
          ctl_data = ovr_en ? ovr_data : $urandom;
          ctl_exc  = ovr_en ? ovr_exc : 3'($urandom_range(0, 7));
        end
      end else if (outstanding) begin
        chk("datain1_hold", Add_Datain1, exp_d1);
        chk("datain2_hold", Add_Datain2, exp_d2);
      end
      prev_dv = (Add_Data_valid === 1'b1);
      if (Op_valid && Op_ready === 1'b1) begin
        h.a = Op_a; h.b = Op_b; h.mode = Op_mode; h.tag = Op_tag;
        q.push_back(h);
        last_push_cyc = cyc;
        pushed_now = 1;
      end
    end
  endtask

  task automatic step();
    @(negedge CLK);
    check_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] m, input logic [TAG_W-1:0] t);
    int n = 0;
    Op_a = a; Op_b = b; Op_mode = m; Op_tag = t; Op_valid = 1'b1;
    do begin step(); n++; end while (!pushed_now && n < 100);
    Op_valid = 1'b0;
    if (!pushed_now) chk_true("push_timeout", 1'b0);
  endtask

  task automatic wait_issue(input int n0, input int budget);
    int k = 0;
    while (issue_cnt == n0 && k < budget) begin step(); k++; end
    if (issue_cnt == n0) chk_true("wait_issue_timeout", 1'b0);
  endtask

  task automatic wait_res(input int n0, input int budget);
    int k = 0;
    while (res_cnt < n0 && k < budget) begin step(); k++; end
    if (res_cnt < n0) chk_true("wait_res_timeout", 1'b0);
  endtask

  initial begin
    int n0, p, s0;
    // Reset values
    step(); step();
    RSTn = 1'b1;
    chk("rst_op_ready", 32'(Op_ready), 32'd1);
    chk("rst_res_valid", 32'(Res_valid), 32'd0);
    chk("rst_res_data", Res_data, 32'd0);
    chk("rst_res_exc", 32'(Res_exc), 32'd0);
    chk("rst_res_tag", 32'(Res_tag), 32'd0);
    chk("rst_add_dv", 32'(Add_Data_valid), 32'd0);
    chk("rst_din1", Add_Datain1, 32'd0);
    chk("rst_din2", Add_Datain2, 32'd0);
    step();

    // ADD 1.0 + 2.0, reply 3.0 after 6 cycles
    Res_ready = 1'b1;
    ovr_en = 1; ovr_data = 32'h4040_0000; ovr_exc = 3'b000; ovr_delay = 6;
    n0 = issue_cnt;
    push_op(32'h3F80_0000, 32'h4000_0000, 3'b000, 4'd5);
    p = last_push_cyc;
    wait_issue(n0, 20);
    chk("t1_issue_latency", 32'(last_issue_cyc - p), 32'd2);
    chk("t1_din2", last_issue_d2, 32'h4000_0000);
    wait_res(1, 40);
    chk("t1_res_latency", 32'(last_res_cyc - last_issue_cyc), 32'd7);
    chk("t1_res_data", last_res_data, 32'h4040_0000);
    chk("t1_res_exc", 32'(last_res_exc), 32'd0);
    chk("t1_res_tag", 32'(last_res_tag), 32'd5);

    // SUB 3.0 - 1.0: B sign flipped on the way out, reply passed back unchanged
    ovr_data = 32'h4000_0000; ovr_exc = 3'b010; ovr_delay = 3;
    n0 = res_cnt;
    push_op(32'h4040_0000, 32'h3F80_0000, 3'b001, 4'd9);
    wait_res(n0 + 1, 40);
    chk("t2_din2", last_issue_d2, 32'hBF80_0000);
    chk("t2_res_data", last_res_data, 32'h4000_0000);
    chk("t2_res_exc", 32'(last_res_exc), 32'd2);
    chk("t2_res_tag", 32'(last_res_tag), 32'd9);

    // Illegal mode: answered locally, nothing issued
    n0 = issue_cnt; s0 = res_cnt;
    push_op(32'h1234_5678, 32'h9ABC_DEF0, 3'b011, 4'd3);
    p = last_push_cyc;
    wait_res(s0 + 1, 20);
    chk("t3_no_issue", 32'(issue_cnt - n0), 32'd0);
    chk("t3_res_latency", 32'(last_res_cyc - p), 32'd2);
    chk("t3_res_exc", 32'(last_res_exc), 32'd4);
    chk("t3_res_data", last_res_data, 32'd0);
    chk("t3_res_tag", 32'(last_res_tag), 32'd3);
    ovr_en = 0;

    // Back-to-back pushes with results stalled. The first op leaves the FIFO as
    // soon as it is popped, so DEPTH more fit behind it before Op_ready drops.
    Res_ready = 1'b0;
    step();
    res_tags.delete();
    s0 = res_cnt;
    for (int i = 0; i < 5; i++) begin
      Op_a = $urandom; Op_b = $urandom; Op_mode = 3'(i % 2); Op_tag = TAG_W'(i);
      Op_valid = 1'b1;
      step();
      chk("t4_accept", 32'(pushed_now), 32'd1);
    end
    Op_valid = 1'b0;
    step();
    chk("t4_ready_low", 32'(Op_ready), 32'd0);
    for (int i = 0; i < 20; i++) step();
    Res_ready = 1'b1;
    wait_res(s0 + 5, 200);
    for (int i = 0; i < 5; i++) begin
      if (i < res_tags.size()) chk("t4_tag_order", 32'(res_tags[i]), 32'(i));
      else chk_true("t4_tag_missing", 1'b0);
    end

    // Reset while waiting on the controller; its late pulse must be ignored
    ovr_en = 1; ovr_data = 32'hDEAD_BEEF; ovr_exc = 3'b000; ovr_delay = 10;
    n0 = issue_cnt;
    push_op(32'h3F80_0000, 32'h3F80_0000, 3'b000, 4'd7);
    wait_issue(n0, 20);
    step(); step();
    s0 = stray_cnt; n0 = res_cnt;
    RSTn = 1'b0;
    step();
    RSTn = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("t5_no_result", 32'(res_cnt - n0), 32'd0);
    chk("t5_res_valid", 32'(Res_valid), 32'd0);
    chk("t5_op_ready", 32'(Op_ready), 32'd1);
    chk_true("t5_late_pulse_sent", stray_cnt > s0);
    ovr_en = 0;

    // Randomized traffic with stray controller pulses
    stray_en = 1;
    for (int i = 0; i < 3000; i++) begin
      int r;
      Op_valid  = ($urandom_range(0, 2) != 0);
      Op_a      = $urandom;
      Op_b      = $urandom;
      r         = $urandom_range(0, 7);
      Op_mode   = (r < 6) ? 3'(r % 2) : 3'($urandom_range(2, 7));
      Op_tag    = TAG_W'($urandom);
      Res_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    Op_valid = 1'b0; Res_ready = 1'b1; stray_en = 0;
    for (int k = 0; k < 500 && q.size() != 0; k++) step();
    chk("rand_drained", 32'(q.size()), 32'd0);
    chk_true("rand_activity", res_cnt > 100);

`ifdef FPU_SEQ_TIMEOUT_EN
    // Controller never answers: watchdog returns EXC_TIMEOUT
    ctl_mute = 1;
    n0 = issue_cnt; s0 = res_cnt;
    push_op(32'h4000_0000, 32'h4000_0000, 3'b000, 4'd11);
    wait_issue(n0, 20);
    wait_res(s0 + 1, 200);
    chk("t6_timeout_latency", 32'(last_res_cyc - last_issue_cyc), 32'(TO_LIM + 1));
    chk("t6_timeout_exc", 32'(last_res_exc), 32'd7);
    chk("t6_timeout_data", last_res_data, 32'd0);
    ctl_mute = 0;
`endif

    for (int i = 0; i < 5; i++) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
